// File: rtl/fpu_norm_pkg.sv
// -----------------------------------------------------------------------------
// fpu_norm_pkg
// Shared constants, helpers and payload type for the pipelined mantissa
// normaliser (fp_norm_pipe) and its MSB encoder.
//   DEF_*          default geometry: 25-bit mantissa incl. carry, hidden bit
//                  at position 23, 8-bit biased exponent, 8-bit MSB index
//   norm_clog2     ceiling log2, used to check that IDX_W can hold an index
//   s1_payload_t   stage-1 payload (data, exp, idx, zero) at default geometry
// -----------------------------------------------------------------------------
package fpu_norm_pkg;

    localparam int DEF_WIDTH    = 25;
    localparam int DEF_NORM_POS = 23;
    localparam int DEF_EXP_W    = 8;
    localparam int DEF_IDX_W    = 8;

    function automatic int norm_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // The pipeline declares an identically laid-out type sized by its own
    // parameters; this one documents the default field order and widths.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_IDX_W-1:0] idx;
        logic                 zero;
    } s1_payload_t;

endpackage

// File: rtl/msb_encoder.sv
// -----------------------------------------------------------------------------
// msb_encoder
// Combinational leading-one detector: reports the index of the highest set bit
// of i_data and flags an all-zero word (index reads 0 in that case).
//   i_data  [WIDTH-1:0]  word to scan
//   o_idx   [IDX_W-1:0]  index of the highest set bit
//   o_zero               i_data is all zero
// -----------------------------------------------------------------------------
module msb_encoder #(
    parameter int WIDTH = 25,
    parameter int IDX_W = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero
);

    always_comb begin
        o_idx = '0;
        // Ascending scan: the last (highest) set bit wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        o_zero = ~|i_data;
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// -----------------------------------------------------------------------------
// fp_norm_pipe
// Two-stage pipelined normaliser for the FPU add/sub datapath. Stage 1
// registers the word, its exponent and the MSB index/zero flag; stage 2
// shifts the leading one onto NORM_POS, collects sticky bits on a right shift
// and adjusts the exponent. Valid/ready flow control, 1 word/cycle, 2-cycle
// latency. Synchronous active-high reset.
//
// Optional build macro NORM_UF_CLAMP_EN: a left shift larger than the exponent
// is limited to the exponent (denormal result, out_exp=0, out_uf=1). Without
// it the full shift is applied, the exponent wraps and out_uf is tied to 0.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready                input handshake
//   in_data  [WIDTH-1:0]             un-normalised mantissa
//   in_exp   [EXP_W-1:0]             exponent for in_data
//   out_valid/out_ready              output handshake
//   out_data [WIDTH-1:0]             normalised mantissa
//   out_exp  [EXP_W-1:0]             adjusted exponent
//   out_index[IDX_W-1:0]             MSB index of the input word
//   out_zero, out_sticky, out_uf     zero input, lost-bit OR, underflow clamp
// -----------------------------------------------------------------------------
module fp_norm_pipe
    import fpu_norm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NORM_POS = DEF_NORM_POS,
    parameter int EXP_W    = DEF_EXP_W,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [EXP_W-1:0] out_exp,
    output logic [IDX_W-1:0] out_index,
    output logic             out_zero,
    output logic             out_sticky,
    output logic             out_uf
);

    if (IDX_W < norm_clog2(WIDTH)) begin : g_idx_w_check
        $error("fp_norm_pipe: IDX_W too narrow for WIDTH");
    end
    if (NORM_POS >= WIDTH) begin : g_norm_pos_check
        $error("fp_norm_pipe: NORM_POS must lie inside WIDTH");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [EXP_W-1:0] exp;
        logic [IDX_W-1:0] idx;
        logic             zero;
    } s1_pl_t;

    localparam logic [IDX_W-1:0] NORM_IDX = IDX_W'(NORM_POS);

    logic                   r_s1_valid;
    s1_pl_t                 r_s1;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [EXP_W-1:0]       r_out_exp;
    logic [IDX_W-1:0]       r_out_index;
    logic                   r_out_zero;
    logic                   r_out_sticky;
    logic                   r_out_uf;

    logic [IDX_W-1:0]       w_enc_idx;
    logic                   w_enc_zero;
    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic [IDX_W-1:0]       w_rsh;
    logic [IDX_W-1:0]       w_lsh;
    logic [WIDTH-1:0]       w_mask;
    logic [WIDTH-1:0]       w_nd;
    logic [EXP_W-1:0]       w_ne;
    logic                   w_st;
    logic                   w_uf;
    logic signed [EXP_W:0]  w_esum;
    logic                   w_unused_esign;

    msb_encoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_msb_encoder (
        .i_data (in_data),
        .o_idx  (w_enc_idx),
        .o_zero (w_enc_zero)
    );

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = !rst && w_s1_adv;

    // Stage-2 shift and exponent adjust, done at EXP_W+1 signed width so the
    // sign bit exposes a left shift that would take the exponent below zero.
    always_comb begin
        w_rsh  = '0;
        w_lsh  = '0;
        w_mask = '0;
        w_nd   = r_s1.data;
        w_ne   = r_s1.exp;
        w_st   = 1'b0;
        w_uf   = 1'b0;
        w_esum = $signed({1'b0, r_s1.exp});
        if (r_s1.zero) begin
            w_nd = '0;
            w_ne = '0;
        end else if (r_s1.idx > NORM_IDX) begin
            w_rsh  = r_s1.idx - NORM_IDX;
            w_mask = ~({WIDTH{1'b1}} << w_rsh);
            w_st   = |(r_s1.data & w_mask);
            w_nd   = r_s1.data >> w_rsh;
            w_esum = $signed({1'b0, r_s1.exp}) + $signed({1'b0, EXP_W'(w_rsh)});
            w_ne   = w_esum[EXP_W-1:0];
        end else if (r_s1.idx < NORM_IDX) begin
            w_lsh  = NORM_IDX - r_s1.idx;
            w_esum = $signed({1'b0, r_s1.exp}) - $signed({1'b0, EXP_W'(w_lsh)});
`ifdef NORM_UF_CLAMP_EN
            if (w_esum[EXP_W]) begin
                // Shift only as far as the exponent allows: denormal result.
                w_lsh  = IDX_W'(r_s1.exp);
                w_esum = '0;
                w_uf   = 1'b1;
            end
`endif
            w_nd = r_s1.data << w_lsh;
            w_ne = w_esum[EXP_W-1:0];
        end
    end

    assign w_unused_esign = w_esum[EXP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1         <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_exp    <= '0;
            r_out_index  <= '0;
            r_out_zero   <= 1'b0;
            r_out_sticky <= 1'b0;
            r_out_uf     <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data   <= w_nd;
                    r_out_exp    <= w_ne;
                    r_out_index  <= r_s1.idx;
                    r_out_zero   <= r_s1.zero;
                    r_out_sticky <= w_st;
                    r_out_uf     <= w_uf;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1.data <= in_data;
                    r_s1.exp  <= in_exp;
                    r_s1.idx  <= w_enc_idx;
                    r_s1.zero <= w_enc_zero;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_exp    = r_out_exp;
    assign out_index  = r_out_index;
    assign out_zero   = r_out_zero;
    assign out_sticky = r_out_sticky;
    assign out_uf     = r_out_uf;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_pipe
// Directed, table-driven bench for fp_norm_pipe at the default geometry
// (WIDTH=25, NORM_POS=23, EXP_W=8). Expected values are hand-computed; the
// underflow rows depend on NORM_UF_CLAMP_EN.
// -----------------------------------------------------------------------------
module tb_fp_norm_pipe;

    localparam int WIDTH = 25;
    localparam int EXP_W = 8;
    localparam int IDX_W = 8;
    localparam int NVEC  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [EXP_W-1:0] out_exp;
    logic [IDX_W-1:0] out_index;
    logic             out_zero;
    logic             out_sticky;
    logic             out_uf;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [EXP_W-1:0] e;
        logic [WIDTH-1:0] o_data;
        logic [EXP_W-1:0] o_exp;
        logic [IDX_W-1:0] o_idx;
        logic             o_zero;
        logic             o_sticky;
        logic             o_uf;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    fp_norm_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_exp    (out_exp),
        .out_index  (out_index),
        .out_zero   (out_zero),
        .out_sticky (out_sticky),
        .out_uf     (out_uf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        bit got;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = vecs[i].d;
        in_exp    = vecs[i].e;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!got) begin
            chk($sformatf("v%0d timeout", i), 32'd0, 32'd1);
        end else begin
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d data", i),   32'(out_data),   32'(vecs[i].o_data));
            chk($sformatf("v%0d exp", i),    32'(out_exp),    32'(vecs[i].o_exp));
            chk($sformatf("v%0d index", i),  32'(out_index),  32'(vecs[i].o_idx));
            chk($sformatf("v%0d zero", i),   32'(out_zero),   32'(vecs[i].o_zero));
            chk($sformatf("v%0d sticky", i), 32'(out_sticky), 32'(vecs[i].o_sticky));
            chk($sformatf("v%0d uf", i),     32'(out_uf),     32'(vecs[i].o_uf));
        end
        @(posedge clk);
    endtask

    initial begin
        int k;
        int n_out;

        //          in_data     exp    out_data    out_exp idx  z  st uf
        vecs[0] = '{25'h0800000, 8'd100, 25'h0800000, 8'd100, 8'd23, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{25'h1000001, 8'd100, 25'h0800000, 8'd101, 8'd24, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{25'h0000010, 8'd100, 25'h0800000, 8'd81,  8'd4,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{25'h0000000, 8'd55,  25'h0000000, 8'd0,   8'd0,  1'b1, 1'b0, 1'b0};
`ifdef NORM_UF_CLAMP_EN
        vecs[4] = '{25'h0000010, 8'd5,   25'h0000200, 8'd0,   8'd4,  1'b0, 1'b0, 1'b1};
        vecs[9] = '{25'h0000003, 8'd0,   25'h0000003, 8'd0,   8'd1,  1'b0, 1'b0, 1'b1};
`else
        vecs[4] = '{25'h0000010, 8'd5,   25'h0800000, 8'd242, 8'd4,  1'b0, 1'b0, 1'b0};
        vecs[9] = '{25'h0000003, 8'd0,   25'h0C00000, 8'd234, 8'd1,  1'b0, 1'b0, 1'b0};
`endif
        vecs[5] = '{25'h1800000, 8'd255, 25'h0C00000, 8'd0,   8'd24, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{25'h0000001, 8'd30,  25'h0800000, 8'd7,   8'd0,  1'b0, 1'b0, 1'b0};
        vecs[7] = '{25'h1FFFFFF, 8'd10,  25'h0FFFFFF, 8'd11,  8'd24, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{25'h0400000, 8'd1,   25'h0800000, 8'd0,   8'd22, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data",  32'(out_data),  32'd0);
        chk("rst out_exp",   32'(out_exp),   32'd0);
        chk("rst out_zero",  32'(out_zero),  32'd0);
        chk("rst in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Back-to-back stream of six words, downstream stalled for cycles 3..5.
        k     = 0;
        n_out = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (k < 6);
            in_data   = (k < 6) ? vecs[k].d : '0;
            in_exp    = (k < 6) ? vecs[k].e : '0;
            #1;
            if (c >= 3 && c <= 5) begin
                chk($sformatf("stall c%0d in_ready", c),  32'(in_ready),  32'd0);
                chk($sformatf("stall c%0d out_valid", c), 32'(out_valid), 32'd1);
                chk($sformatf("stall c%0d held data", c), 32'(out_data),  32'(vecs[1].o_data));
                chk($sformatf("stall c%0d held exp", c),  32'(out_exp),   32'(vecs[1].o_exp));
            end
            if (out_valid && out_ready) begin
                if (n_out < 6) begin
                    chk($sformatf("stream w%0d data", n_out), 32'(out_data), 32'(vecs[n_out].o_data));
                    chk($sformatf("stream w%0d exp", n_out),  32'(out_exp),  32'(vecs[n_out].o_exp));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                k++;
            end
            @(posedge clk);
        end
        chk("stream accepted", 32'(k), 32'd6);
        chk("stream emitted",  32'(n_out), 32'd6);

        // Reset with two words in flight and downstream stalled.
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = vecs[2].d;
        in_exp    = vecs[2].e;
        @(posedge clk);
        @(negedge clk);
        in_data = vecs[7].d;
        in_exp  = vecs[7].e;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre-rst out_valid", 32'(out_valid), 32'd1);
        chk("pre-rst in_ready",  32'(in_ready),  32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-rst out_valid", 32'(out_valid), 32'd0);
        chk("mid-rst in_ready",  32'(in_ready),  32'd0);
        chk("mid-rst out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("after-rst in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("after-rst no ghost word", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
